// File: rtl/fir_channel_scheduler.sv
// Shares one serial FIR engine across NCH sample channels, picking channels round-robin.
// Latency: sample accept -> eng_start after 2 cycles; eng_done -> out_valid on the next cycle.
// Backpressure: each channel has a 1-deep hold reg (in_ready low while full); a result is held until out_ready.
//
// Ports:
//   clk, rst_n                            clock, asynchronous active-low reset
//   in_data / in_valid / in_ready         per-channel sample handshake, channel i at [i*WIDTH +: WIDTH]
//   eng_sample / eng_chan / eng_start     job launch to the engine; sample and channel hold until the next launch
//   eng_done / eng_result                 engine completion pulse and its result
//   out_data / out_chan / out_valid / out_ready   channel-tagged result handshake
//   timeout_err / clear_err               sticky watchdog flag and its clear (a new timeout beats a clear)
module fir_channel_scheduler #(
  parameter int WIDTH   = 16,
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int TIMEOUT = 160
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     eng_sample,
  output logic [CHW-1:0]       eng_chan,
  output logic                 eng_start,
  input  logic                 eng_done,
  input  logic [WIDTH-1:0]     eng_result,
  output logic [WIDTH-1:0]     out_data,
  output logic [CHW-1:0]       out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 timeout_err,
  input  logic                 clear_err
);

  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_e;

  state_e           state_q, state_d;

  logic [NCH-1:0]   hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q [NCH];
  logic [WIDTH-1:0] hold_data_d [NCH];
  logic [CHW-1:0]   last_grant_q, last_grant_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [WIDTH-1:0] eng_sample_q, eng_sample_d;
  logic [CHW-1:0]   eng_chan_q, eng_chan_d;
  logic             eng_start_q, eng_start_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CHW-1:0]   out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic             timeout_err_q, timeout_err_d;

  logic             any_pending;
  logic             wd_expired;
  logic             wd_fire;
  logic [CHW-1:0]   grant_c;
  logic [CHW-1:0]   idx_c;
  logic             grant_found;

  assign any_pending = |hold_valid_q;
  assign wd_expired  = (wd_q == WDW'(TIMEOUT - 1));

  // Round-robin search: first pending channel strictly after last_grant, wrapping mod NCH.
  always_comb begin
    grant_c     = '0;
    idx_c       = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx_c = CHW'((int'(last_grant_q) + k) % NCH);
      if (!grant_found && hold_valid_q[idx_c]) begin
        grant_c     = idx_c;
        grant_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_pending) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      // Completion beats the watchdog when both land on the same cycle.
      S_WAIT: begin
        if (eng_done)        state_d = S_OUTPUT;
        else if (wd_expired) state_d = S_IDLE;
      end
      S_OUTPUT: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-state logic. Engine launch signals are registered on the
  // IDLE->ISSUE edge so eng_start is a clean one-cycle pulse during ISSUE.
  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;
    last_grant_d  = last_grant_q;
    wd_d          = wd_q;
    eng_sample_d  = eng_sample_q;
    eng_chan_d    = eng_chan_q;
    eng_start_d   = 1'b0;
    out_data_d    = out_data_q;
    out_chan_d    = out_chan_q;
    out_valid_d   = out_valid_q;
    wd_fire       = 1'b0;

    // Accept only into empty hold regs, so a held sample is never overwritten.
    for (int i = 0; i < NCH; i++) begin
      if (in_valid[i] && !hold_valid_q[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = in_data[i*WIDTH +: WIDTH];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (any_pending) begin
          last_grant_d = grant_c;
          eng_chan_d   = grant_c;
          eng_sample_d = hold_data_q[grant_c];
          eng_start_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        // The granted channel's in_ready is held low during ISSUE, so no accept collides here.
        hold_valid_d[eng_chan_q] = 1'b0;
        wd_d                     = '0;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (eng_done) begin
          out_data_d  = eng_result;
          out_chan_d  = eng_chan_q;
          out_valid_d = 1'b1;
        end else if (wd_expired) begin
          wd_fire = 1'b1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase

    if (wd_fire)        timeout_err_d = 1'b1;
    else if (clear_err) timeout_err_d = 1'b0;
    else                timeout_err_d = timeout_err_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q  <= '0;
      for (int i = 0; i < NCH; i++) hold_data_q[i] <= '0;
      last_grant_q  <= CHW'(NCH - 1);
      wd_q          <= '0;
      eng_sample_q  <= '0;
      eng_chan_q    <= '0;
      eng_start_q   <= 1'b0;
      out_data_q    <= '0;
      out_chan_q    <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      last_grant_q  <= last_grant_d;
      wd_q          <= wd_d;
      eng_sample_q  <= eng_sample_d;
      eng_chan_q    <= eng_chan_d;
      eng_start_q   <= eng_start_d;
      out_data_q    <= out_data_d;
      out_chan_q    <= out_chan_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_ready    = ~hold_valid_q;
  assign eng_sample  = eng_sample_q;
  assign eng_chan    = eng_chan_q;
  assign eng_start   = eng_start_q;
  assign out_data    = out_data_q;
  assign out_chan    = out_chan_q;
  assign out_valid   = out_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Time-multiplexes one shared 128-tap serial FIR engine across NCH independent sample channels. Each channel has a 1-deep holding register with a valid/ready handshake. A round-robin arbiter picks the next pending channel and launches one engine job. The block then waits for the engine result, with a watchdog, and returns the result tagged with its channel on a valid/ready output.

Parameters:
WIDTH, 16, sample/result width (signed)
NCH, 4, number of input channels
CHW, 2, channel index width (clog2(NCH))
TIMEOUT, 160, max cycles from eng_start to eng_done before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  NCH*WIDTH  channel i sample at [i*WIDTH +: WIDTH]
in_valid  in  NCH  per-channel sample valid
in_ready  out  NCH  per-channel holding register empty
eng_sample  out  WIDTH  sample presented to FIR engine
eng_chan  out  CHW  channel of current job
eng_start  out  1  one-cycle job launch pulse
eng_done  in  1  one-cycle engine completion pulse
eng_result  in  WIDTH  engine output, valid with eng_done
out_data  out  WIDTH  filtered sample
out_chan  out  CHW  channel of out_data
out_valid  out  1  output valid
out_ready  in  1  downstream accept
timeout_err  out  1  sticky watchdog flag
clear_err  in  1  clears timeout_err

Behaviour:
- Reset, async on rst_n low: state=IDLE; hold_valid all 0, so in_ready all 1 after release; eng_start, eng_sample, eng_chan, out_valid, out_data, out_chan, timeout_err = 0; last_grant=NCH-1, so ch0 has first priority; watchdog=0. Reset mid-job discards the job and any pending samples.
- Holding regs: in_ready[i] = ~hold_valid[i], driven from a register. On in_valid[i]&in_ready[i], latch data and set hold_valid[i].
- FSM IDLE -> ISSUE -> WAIT -> OUTPUT -> IDLE.
- IDLE: if any hold_valid, grant the first set channel searching from last_grant+1 upward, wrapping mod NCH. Register grant and last_grant, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): eng_start=1, eng_sample=hold_data[grant], eng_chan=grant. Clear hold_valid[grant], so in_ready[grant] is 1 next cycle. Clear the watchdog. Go to WAIT.
- eng_sample and eng_chan hold their value until the next ISSUE.
- WAIT: watchdog increments each cycle.
  - eng_done=1: latch out_data=eng_result and out_chan=eng_chan, go to OUTPUT.
  - Else if watchdog==TIMEOUT-1: set timeout_err, go to IDLE, no output.
  - eng_done on the same cycle as the timeout condition: done wins.
- OUTPUT: out_valid=1; out_data and out_chan stay stable while out_ready=0. On out_ready=1, clear out_valid and go to IDLE.
- eng_done in any state other than WAIT is ignored.
- Latency:
  - Accept at edge t: grant at t+1, eng_start high in cycle after t+1, so eng_start is visible 2 cycles after acceptance when IDLE.
  - eng_done at edge d: out_valid at d+1.
  - One job in flight at a time. New samples are accepted during any state into empty holding registers.
- Back-to-back: after the OUTPUT handshake, IDLE arbitrates in the next cycle. There is no bypass from OUTPUT to ISSUE.
- A channel with hold_valid set backpressures: in_ready=0 until its job is issued. Data is never overwritten.
- timeout_err: set by watchdog, cleared by clear_err. Set and clear in the same cycle: set wins.
- Arithmetic: the block does no arithmetic on samples; eng_result passes through unmodified. Watchdog width is clog2(TIMEOUT)+1.

Test Plan:
1. ch2 sends 0x0100; engine model pulses eng_done 128 cycles after eng_start with 0x1234 -> eng_start 2 cycles after accept; eng_sample=0x0100, eng_chan=2; out_valid next cycle with out_data=0x1234, out_chan=2; in_ready[2] back to 1 after ISSUE.
2. All 4 channels valid in the same cycle (0x0011, 0x0022, 0x0033, 0x0044) with out_ready=1 -> eng_chan sequence 0,1,2,3; out_chan sequence 0,1,2,3; no sample lost or duplicated.
3. ch0 continuously valid, ch3 becomes valid during a ch0 job -> next grant is ch3, then ch0; no channel starves beyond NCH-1 jobs.
4. out_ready held 0 for 10 cycles in OUTPUT -> out_valid stays 1, out_data/out_chan stable, no eng_start pulse until the handshake completes.
5. Engine never asserts eng_done -> timeout_err=1 exactly TIMEOUT cycles after eng_start, FSM returns to IDLE and the next pending channel is issued; clear_err=1 then drops timeout_err; clear_err together with a new timeout leaves it at 1.
6. rst_n low mid-WAIT with 2 samples pending -> all outputs 0 immediately; in_ready=4'b1111 after release; a late eng_done from the engine model is ignored; the first grant after reset is ch0.
